data_mem_copier: RTL and testbench

//  Bus initiator on the data-memory port protocol, i.e. the requester side of the interface data_mem answers.

---
 rtl/dmc_pkg.sv | 21 ++
 rtl/data_mem_copier.sv | 186 ++++++++++++++++++
 tb/tb_data_mem_copier.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmc_pkg.sv
// Shared definitions for the data-memory copier: FSM state encoding, bus byte masks, word size.
package dmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_FINISH
  } dmc_state_t;

  localparam logic [3:0] MASK_WORD  = 4'b1111;
  localparam logic [3:0] MASK_NONE  = 4'b0000;
  localparam int         WORD_BYTES = 4;

  function automatic logic addr_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_copier.sv
// Word-by-word memory copier acting as a requester on the data-memory bus (read, then write, per word).
// Optional running checksum of copied words: define DATA_MEM_COPIER_CHECKSUM_EN.
module data_mem_copier
  import dmc_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              bus_gnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [3:0]        mem_sign_mask,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_clk_stall
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);

  dmc_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] src_reg, src_next;
  logic [ADDR_W-1:0] dst_reg, dst_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]  remaining_reg, remaining_next;
  logic [31:0]       data_reg, data_next;
  logic [31:0]       wr_data_reg, wr_data_next;
  logic [3:0]        mask_reg, mask_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              rd_reg, rd_next;
  logic              wr_reg, wr_next;

`ifdef DATA_MEM_COPIER_CHECKSUM_EN
  logic [31:0]       checksum_reg, checksum_next;
  assign checksum = checksum_reg;
`else
  assign checksum = 32'h0;
`endif

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign err           = err_reg;
  assign mem_addr      = addr_reg;
  assign mem_wr_data   = wr_data_reg;
  assign mem_memwrite  = wr_reg;
  assign mem_memread   = rd_reg;
  assign mem_sign_mask = mask_reg;

  // All bus outputs are registered: each is set on the edge that leaves the requesting state.
  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    data_next      = data_reg;
    wr_data_next   = wr_data_reg;
    mask_next      = mask_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    rd_next        = rd_reg;
    wr_next        = wr_reg;
`ifdef DATA_MEM_COPIER_CHECKSUM_EN
    checksum_next  = checksum_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (!(addr_aligned(src_addr[1:0]) && addr_aligned(dst_addr[1:0]))) begin
            err_next = 1'b1;
          end else begin
`ifdef DATA_MEM_COPIER_CHECKSUM_EN
            checksum_next = 32'h0;
`endif
            if (word_count == '0) begin
              state_next = ST_FINISH;
            end else begin
              src_next       = src_addr;
              dst_next       = dst_addr;
              remaining_next = word_count;
              busy_next      = 1'b1;
              state_next     = ST_RD_REQ;
            end
          end
        end
      end
      ST_RD_REQ: begin
        if (bus_gnt) begin
          rd_next    = 1'b1;
          addr_next  = src_reg;
          mask_next  = MASK_WORD;
          state_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (!mem_clk_stall) begin
          data_next  = mem_read_data;
          rd_next    = 1'b0;
          mask_next  = MASK_NONE;
          state_next = ST_WR_REQ;
`ifdef DATA_MEM_COPIER_CHECKSUM_EN
          checksum_next = checksum_reg + mem_read_data;
`endif
        end
      end
      ST_WR_REQ: begin
        // Grant is only arbitrated before the read; the write follows unconditionally.
        wr_next      = 1'b1;
        addr_next    = dst_reg;
        wr_data_next = data_reg;
        mask_next    = MASK_WORD;
        state_next   = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (!mem_clk_stall) begin
          wr_next        = 1'b0;
          mask_next      = MASK_NONE;
          src_next       = src_reg + ADDR_STEP;
          dst_next       = dst_reg + ADDR_STEP;
          remaining_next = remaining_reg - CNT_W'(1);
          state_next     = (remaining_reg == CNT_W'(1)) ? ST_FINISH : ST_RD_REQ;
        end
      end
      ST_FINISH: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      addr_reg      <= '0;
      remaining_reg <= '0;
      data_reg      <= '0;
      wr_data_reg   <= '0;
      mask_reg      <= MASK_NONE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
`ifdef DATA_MEM_COPIER_CHECKSUM_EN
      checksum_reg  <= 32'h0;
`endif
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      data_reg      <= data_next;
      wr_data_reg   <= wr_data_next;
      mask_reg      <= mask_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      rd_reg        <= rd_next;
      wr_reg        <= wr_next;
`ifdef DATA_MEM_COPIER_CHECKSUM_EN
      checksum_reg  <= checksum_next;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_copier.sv
// Self-checking bench for data_mem_copier: memory responder with programmable stalls plus a
// sequential word-copy reference model; honours DATA_MEM_COPIER_CHECKSUM_EN when defined.
module tb_data_mem_copier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] word_count = '0;
  logic        bus_gnt = 1'b0;
  logic        busy, done, err;
  logic [31:0] checksum, mem_addr, mem_wr_data;
  logic        mem_memwrite, mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = '0;
  logic        mem_clk_stall = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          rd_stall = 0;
  int          wr_stall = 0;
  int          stall_cnt = 0;
  logic [31:0] exp_checksum = '0;

  data_mem_copier #(.CNT_W(16), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .bus_gnt(bus_gnt), .busy(busy), .done(done), .err(err),
    .checksum(checksum), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  // Responder: stalls each request a programmable number of cycles, then completes it.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_clk_stall = 1'b0;
      stall_cnt = 0;
    end else if (mem_memread || mem_memwrite) begin
      if (stall_cnt < (mem_memread ? rd_stall : wr_stall)) begin
        mem_clk_stall = 1'b1;
        stall_cnt++;
        mem_read_data = $urandom;
      end else begin
        mem_clk_stall = 1'b0;
        stall_cnt = 0;
        if (mem_memread) begin
          mem_read_data = mem[mem_addr[11:2]];
          rd_log.push_back(mem_addr);
        end else begin
          mem[mem_addr[11:2]] = mem_wr_data;
          wr_addr_log.push_back(mem_addr);
          wr_data_log.push_back(mem_wr_data);
        end
      end
    end else begin
      mem_clk_stall = 1'b0;
      stall_cnt = 0;
    end
  end

  // Bus protocol monitor: exclusivity, mask, and request stability while stalled.
  logic        prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  logic [3:0]  exp_mask;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if (mem_memread && mem_memwrite) $display("FAIL bus_exclusive rd=%0b wr=%0b required not both", mem_memread, mem_memwrite);
      else n_pass++;
      exp_mask = (mem_memread || mem_memwrite) ? 4'hF : 4'h0;
      n_checks++;
      if (mem_sign_mask !== exp_mask) $display("FAIL sign_mask got=%h exp=%h", mem_sign_mask, exp_mask);
      else n_pass++;
      if (prev_rd && mem_memread) begin
        n_checks++;
        if (mem_addr !== prev_addr) $display("FAIL rd_hold addr got=%h exp=%h", mem_addr, prev_addr);
        else n_pass++;
      end
      if (prev_wr && mem_memwrite) begin
        n_checks++;
        if (mem_addr !== prev_addr || mem_wr_data !== prev_data)
          $display("FAIL wr_hold got=%h/%h exp=%h/%h", mem_addr, mem_wr_data, prev_addr, prev_data);
        else n_pass++;
      end
    end
    prev_rd = mem_memread;
    prev_wr = mem_memwrite;
    prev_addr = mem_addr;
    prev_data = mem_wr_data;
  end

  // One full copy: builds the expected bus traffic and latency from the copy rules, runs, compares.
  task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                          input int cnt, input int rs, input int ws, input int gnt_delay,
                          input bit drop_gnt, input bit poke);
    logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
    logic [31:0] sum, a, b, d;
    int lat, k, bad;
    bit got, saw_err;
    sum = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < cnt; i++) begin
      a = src + 32'(4 * i);
      b = dst + 32'(4 * i);
      d = ref_mem[a[11:2]];
      ref_mem[b[11:2]] = d;
      exp_rd.push_back(a);
      exp_wa.push_back(b);
      exp_wd.push_back(d);
      sum = sum + d;
    end
    lat = 4 * cnt + 2 + cnt * (rs + ws) + ((cnt > 0) ? gnt_delay : 0);
    rd_stall = rs;
    wr_stall = ws;
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    @(posedge clk); #1;
    src_addr = src;
    dst_addr = dst;
    word_count = 16'(cnt);
    start = 1'b1;
    bus_gnt = (gnt_delay == 0);
    k = 0;
    got = 0;
    saw_err = 0;
    while (!got && k < 4000) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        start = 1'b0;
        n_checks++;
        if (busy !== (cnt > 0)) $display("FAIL %s_busy_after_start got=%0b exp=%0b", name, busy, (cnt > 0));
        else n_pass++;
      end
      if (poke && k == 3) begin
        start = 1'b1;
        src_addr = src + 32'h2;
        word_count = 16'(cnt + 1);
      end
      if (poke && k == 4) begin
        start = 1'b0;
        src_addr = src;
        word_count = 16'(cnt);
      end
      if (err) saw_err = 1;
      if (gnt_delay > 0 && k <= gnt_delay + 1) begin
        n_checks++;
        if (mem_memread !== 1'b0) $display("FAIL %s_gnt_wait cycle=%0d memread got=%0b exp=0", name, k, mem_memread);
        else n_pass++;
      end
      if (done) got = 1;
      bus_gnt = (k > gnt_delay) && !(drop_gnt && mem_memwrite);
    end
    bus_gnt = 1'b1;
    $display("copy %-12s src=%h dst=%h words=%0d cycles=%0d", name, src, dst, cnt, k);
    n_checks++;
    if (!got || k != lat) $display("FAIL %s_latency got=%0d (done_seen=%0b) exp=%0d", name, k, got, lat);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s_busy_at_done got=%0b exp=0", name, busy);
    else n_pass++;
    n_checks++;
    if (saw_err) $display("FAIL %s_spurious_err got=1 exp=0", name);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL %s_done_width got=%0b exp=0", name, done);
    else n_pass++;
    bad = 0;
    if (rd_log.size() != cnt || wr_addr_log.size() != cnt) bad = -1;
    else for (int i = 0; i < cnt; i++)
      if (rd_log[i] !== exp_rd[i] || wr_addr_log[i] !== exp_wa[i] || wr_data_log[i] !== exp_wd[i]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL %s_bus_log reads=%0d writes=%0d exp=%0d mismatched=%0d",
                           name, rd_log.size(), wr_addr_log.size(), cnt, bad);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL %s_memory got=%0d differing words exp=0", name, bad);
    else n_pass++;
`ifdef DATA_MEM_COPIER_CHECKSUM_EN
    exp_checksum = sum;
`else
    exp_checksum = 32'h0;
`endif
    n_checks++;
    if (checksum !== exp_checksum) $display("FAIL %s_checksum got=%h exp=%h", name, checksum, exp_checksum);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, err, mem_memread, mem_memwrite, mem_sign_mask, mem_addr, mem_wr_data, checksum} !== '0)
      $display("FAIL reset_outputs got busy=%0b done=%0b err=%0b rd=%0b wr=%0b mask=%h addr=%h wdata=%h csum=%h exp all zero",
               busy, done, err, mem_memread, mem_memwrite, mem_sign_mask, mem_addr, mem_wr_data, checksum);
    else n_pass++;
    rst_n = 1'b1;
    exp_checksum = '0;
    $display("reset released");
  endtask

  task automatic test_basic();
    run_copy("basic", 32'h100, 32'h200, 4, 0, 0, 0, 0, 0);
    n_checks++;
    if (wr_addr_log.size() != 4 || wr_addr_log[3] !== 32'h20C)
      $display("FAIL basic_last_dst got_writes=%0d exp_last=0000020c", wr_addr_log.size());
    else n_pass++;
  endtask

  task automatic test_read_stall();
    run_copy("read_stall", 32'h100, 32'h280, 4, 3, 0, 0, 0, 0);
  endtask

  task automatic test_zero_and_error();
    logic [31:0] bad_src [2];
    logic [31:0] bad_dst [2];
    bad_src[0] = 32'h102; bad_dst[0] = 32'h200;
    bad_src[1] = 32'h100; bad_dst[1] = 32'h201;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      src_addr = bad_src[c];
      dst_addr = bad_dst[c];
      word_count = 16'd4;
      start = 1'b1;
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      $display("misaligned start src=%h dst=%h err=%0b", bad_src[c], bad_dst[c], err);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0) $display("FAIL misalign_err case=%0d got err=%0b busy=%0b exp err=1 busy=0", c, err, busy);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0 || mem_memread !== 1'b0 || checksum !== exp_checksum)
        $display("FAIL misalign_after case=%0d got err=%0b busy=%0b rd=%0b csum=%h exp 0/0/0/%h",
                 c, err, busy, mem_memread, checksum, exp_checksum);
      else n_pass++;
    end
    run_copy("zero_count", 32'h300, 32'h340, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_grant();
    run_copy("grant", 32'h180, 32'h380, 2, 0, 3, 5, 1, 0);
  endtask

  task automatic test_reset_mid_copy();
    int k, rises;
    logic prev;
    rd_stall = 2;
    wr_stall = 0;
    @(posedge clk); #1;
    src_addr = 32'h400;
    dst_addr = 32'h500;
    word_count = 16'd4;
    start = 1'b1;
    bus_gnt = 1'b1;
    k = 0;
    rises = 0;
    prev = 1'b0;
    while (rises < 2 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) start = 1'b0;
      if (mem_memread && !prev) rises++;
      prev = mem_memread;
    end
    n_checks++;
    if (rises < 2) $display("FAIL midreset_reach_word2 got=%0d reads exp=2", rises);
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    $display("reset asserted during word-2 read at cycle %0d", k);
    n_checks++;
    if ({busy, done, err, mem_memread, mem_memwrite, mem_sign_mask, mem_addr, mem_wr_data, checksum} !== '0)
      $display("FAIL midreset_outputs got busy=%0b done=%0b err=%0b rd=%0b wr=%0b mask=%h addr=%h wdata=%h csum=%h exp all zero",
               busy, done, err, mem_memread, mem_memwrite, mem_sign_mask, mem_addr, mem_wr_data, checksum);
    else n_pass++;
    rst_n = 1'b1;
    exp_checksum = '0;
    run_copy("after_reset", 32'h400, 32'h500, 4, 1, 1, 0, 0, 0);
  endtask

  task automatic test_checksum();
    logic [31:0] exp;
    mem[10'h180] = 32'h1;
    mem[10'h181] = 32'h2;
    mem[10'h182] = 32'h3;
    mem[10'h183] = 32'hFFFF_FFFF;
    run_copy("checksum", 32'h600, 32'h700, 4, 0, 0, 0, 0, 0);
`ifdef DATA_MEM_COPIER_CHECKSUM_EN
    exp = 32'h0000_0005;
`else
    exp = 32'h0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (checksum !== exp) $display("FAIL checksum_hold got=%h exp=%h", checksum, exp);
    else n_pass++;
  endtask

  task automatic test_wrap();
    run_copy("wrap", 32'hFFFF_FFF8, 32'h800, 4, 0, 1, 0, 0, 0);
  endtask

  task automatic test_random_copies();
    logic [31:0] s, d;
    for (int it = 0; it < 10; it++) begin
      s = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      d = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      run_copy("random", s, d, $urandom_range(1, 8), $urandom_range(0, 3), $urandom_range(0, 2),
               $urandom_range(0, 3), (it % 2 == 1), (it % 3 == 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_read_stall();
    test_zero_and_error();
    test_grant();
    test_reset_mid_copy();
    test_checksum();
    test_wrap();
    test_random_copies();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
